game_countdown_timer: RTL and testbench
=======================================

Name: game_countdown_timer

Overview:
- Consumer end of the divided-tick chain. Takes the slow tick produced by the clock-divider blocks and runs a BCD countdown in SS.cc format (seconds 00-99, centiseconds 00-99) for the shooting-game round timer.
- Drives the seven-segment display digits.
- Signals end of round to the game-control FSM with a one-cycle time_up pulse.
- Handles load, start and pause commands from game control.

Parameters:
- DEFAULT_SEC, 8'h60, BCD seconds value loaded at reset.
- TICKS_PER_CS, 1, number of tick_in rising edges per centisecond decrement (1 when fed a 10 ms tick). Legal range 1-15.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- tick_in  in  1  divided time-base tick. May be high for many clk cycles; only its rising edge counts.
- load  in  1  load preset_sec and clear centiseconds.
- start  in  1  start or resume the countdown.
- pause  in  1  freeze the countdown.
- preset_sec  in  8  BCD seconds: [7:4] tens, [3:0] units.
- sec_bcd  out  8  current seconds, BCD.
- cs_bcd  out  8  current centiseconds, BCD.
- running  out  1  high while in RUN.
- expired  out  1  high while in DONE.
- time_up  out  1  one-cycle pulse on entry to DONE.

Behaviour:

Reset (rst=1 at a clk edge):
- state=IDLE, sec_bcd=DEFAULT_SEC, cs_bcd=8'h00.
- running=0, expired=0, time_up=0.
- Tick-edge register and prescaler cleared.
- Reset mid-RUN discards the current count.

Tick detection:
- tick_d is tick_in registered; edge = tick_in & ~tick_d.
- A 4-bit prescaler counts edges. A decrement strobe fires on the edge that brings it to TICKS_PER_CS-1; the prescaler then wraps to 0.
- The prescaler advances only in RUN and holds in PAUSE.

States:
- IDLE: count static. start=1 -> RUN if count != 0000; otherwise -> DONE with a time_up pulse.
- RUN: each decrement strobe decrements cs by 1 with a BCD borrow chain.
  - cs 00 borrows one second: cs becomes 99, sec decrements.
  - Example: 10.00 -> 09.99.
  - When the decrement produces 00.00, the next state is DONE. time_up=1 for exactly that one cycle, and the digits show 00.00 in the same cycle.
  - pause=1 -> PAUSE.
- PAUSE: count and prescaler frozen. start=1 -> RUN.
- DONE: expired=1 and the count holds at 00.00. Ticks are ignored. Only load or rst leaves DONE.

Command rules:
- load=1 (any state) -> IDLE. sec_bcd=preset_sec with each nibble >9 clamped to 9. cs_bcd=00. Prescaler cleared.
- Priority: rst > load > pause (in RUN) > start. In IDLE, PAUSE and DONE, pause has no effect.
- A decrement strobe in the same cycle as pause in RUN is applied, then the state goes to PAUSE.
- A decrement strobe in the same cycle as load is discarded.

Latency and outputs:
- A digit change is visible on the clk edge after the first cycle tick_in is sampled high (with TICKS_PER_CS=1).
- start -> running=1 one cycle later.
- All outputs are registered; none is combinational from inputs.
- running=(state==RUN). expired=(state==DONE).

Decomposition:
- Shared include timer_defs.vh holds:
  - state encodings IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
  - BCD constants BCD_NINE=4'h9 and BCD_ZERO=4'h0.
- One sub-module, bcd_down_digit:
  - Ports: 4-bit value, borrow_in, dec_en, load, load_val; outputs value and borrow_out.
  - Wraps 0 -> 9 with borrow_out=1.
  - Clamps load_val >9 to 9.
  - Instantiated four times in a borrow chain.

Test Plan:
- Reset check: rst 2 cycles -> sec_bcd=8'h60, cs_bcd=8'h00, running=0, expired=0, time_up=0.
- Borrow chain: load preset_sec=8'h10, start, one tick edge (tick_in held high 5 cycles) -> exactly one decrement to 09.99. A second edge -> 09.98.
- Expiry: preset 8'h00, manually step from 00.02 (preset 8'h01 then 98 ticks) -> the next 2 edges reach 00.00. time_up high exactly 1 cycle, expired=1. Further ticks leave 00.00 and time_up=0.
- Pause/tick coincidence: in RUN at 05.00, pause and a tick edge in the same cycle -> 04.99 and PAUSE. Later ticks produce no change. start -> RUN, and the next edge gives 04.98.
- Load priority and clamp: in RUN, load=1 with preset_sec=8'hA7 coinciding with a tick edge -> IDLE, sec_bcd=8'h97, cs_bcd=00, running=0.
- Zero start: preset 8'h00, load, start -> DONE next cycle with a one-cycle time_up, expired=1. rst mid-RUN -> IDLE with 60.00.

Source files
------------

// File: rtl/game_countdown_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_countdown_timer_pkg
//  Description : Shared types and constants for the game round countdown
//                timer: FSM state encoding and BCD digit limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'h9;
  localparam logic [3:0] BCD_ZERO = 4'h0;

endpackage
`default_nettype wire

// File: rtl/game_countdown_timer_bcd_down_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_down_digit
//  Description : One BCD decade of a down-counter. Decrements when both
//                dec_en_i and borrow_in_i are high, wrapping 0 -> 9. A load
//                takes priority and clamps values above 9 to 9.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                dec_en_i          - global decrement strobe
//                borrow_in_i       - borrow from the less significant digit
//                load_i/load_val_i - synchronous load and its value
//                value_o           - current digit
//                borrow_out_o      - this digit is 0 while a borrow arrives
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_digit
  import game_countdown_timer_pkg::*;
#(
  parameter logic [3:0] RESET_VAL = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_en_i,
  input  logic       borrow_in_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic [3:0] value_o,
  output logic       borrow_out_o
);

  logic [3:0] value_q;
  logic [3:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = (load_val_i > BCD_NINE) ? BCD_NINE : load_val_i;
    end else if (dec_en_i && borrow_in_i) begin
      value_d = (value_q == BCD_ZERO) ? BCD_NINE : (value_q - 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= RESET_VAL;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o      = value_q;
  assign borrow_out_o = borrow_in_i && (value_q == BCD_ZERO);

endmodule
`default_nettype wire

// File: rtl/game_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : game_countdown_timer
//  Description : SS.cc BCD round timer driven by a divided tick. Counts down
//                in RUN, freezes in PAUSE, signals DONE with a one-cycle
//                time_up pulse. load/start/pause come from game control.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                tick_in           - slow time base, rising edge counted
//                load, preset_sec  - load BCD seconds, clear centiseconds
//                start, pause      - run/resume and freeze commands
//                sec_bcd, cs_bcd   - current count, BCD
//                running, expired  - state==RUN, state==DONE
//                time_up           - one-cycle pulse on entry to DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module game_countdown_timer
  import game_countdown_timer_pkg::*;
#(
  parameter logic [7:0] DEFAULT_SEC  = 8'h60,
  parameter int         TICKS_PER_CS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [7:0] preset_sec,
  output logic [7:0] sec_bcd,
  output logic [7:0] cs_bcd,
  output logic       running,
  output logic       expired,
  output logic       time_up
);

  localparam logic [3:0]  PRESC_LAST  = 4'(TICKS_PER_CS - 1);
  localparam logic [15:0] RESET_COUNT = {DEFAULT_SEC, 8'h00};

  state_e      state_q, state_d;
  logic [3:0]  presc_q, presc_d;
  logic        tick_q;
  logic        running_q, expired_q, time_up_q;

  logic        w_edge;
  logic        w_strobe;
  logic        w_last;
  logic        w_count_zero;
  logic [15:0] w_count;
  logic [15:0] w_load_count;
  logic [4:0]  w_borrow;

  assign w_edge       = tick_in && !tick_q;
  // A strobe coinciding with load is dropped: the load wins outright.
  assign w_strobe     = (state_q == RUN) && w_edge && (presc_q == PRESC_LAST) && !load;
  assign w_last       = w_strobe && (w_count == 16'h0001);
  assign w_load_count = {preset_sec, 8'h00};

  // Digit chain, index 0 = centisecond units. The chain is seeded with a
  // constant borrow, so the borrow leaving the top digit is high exactly
  // when every digit is zero.
  assign w_borrow[0]  = 1'b1;
  assign w_count_zero = w_borrow[4];

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_down_digit #(
      .RESET_VAL (RESET_COUNT[4*i +: 4])
    ) u_digit (
      .clk          (clk),
      .rst          (rst),
      .dec_en_i     (w_strobe),
      .borrow_in_i  (w_borrow[i]),
      .load_i       (load),
      .load_val_i   (w_load_count[4*i +: 4]),
      .value_o      (w_count[4*i +: 4]),
      .borrow_out_o (w_borrow[i+1])
    );
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    if (load) begin
      state_d = IDLE;
      presc_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = w_count_zero ? DONE : RUN;
          end
        end
        RUN: begin
          if (w_edge) begin
            presc_d = (presc_q == PRESC_LAST) ? 4'd0 : (presc_q + 4'd1);
          end
          // Reaching 00.00 ends the round even if pause arrives together.
          if (w_last) begin
            state_d = DONE;
          end else if (pause) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (start) begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= 4'd0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tick_q    <= tick_in;
      running_q <= (state_d == RUN);
      expired_q <= (state_d == DONE);
      time_up_q <= (state_d == DONE) && (state_q != DONE);
    end
  end

  assign sec_bcd = w_count[15:8];
  assign cs_bcd  = w_count[7:0];
  assign running = running_q;
  assign expired = expired_q;
  assign time_up = time_up_q;

endmodule
`default_nettype wire

// File: tb/tb_game_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_countdown_timer
//  Description : Directed self-checking bench for game_countdown_timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_countdown_timer;

  logic       clk;
  logic       rst;
  logic       tick_in;
  logic       load;
  logic       start;
  logic       pause;
  logic [7:0] preset_sec;
  logic [7:0] sec_bcd;
  logic [7:0] cs_bcd;
  logic       running;
  logic       expired;
  logic       time_up;

  int n_cmp;
  int n_err;

  game_countdown_timer #(
    .DEFAULT_SEC  (8'h60),
    .TICKS_PER_CS (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_in    (tick_in),
    .load       (load),
    .start      (start),
    .pause      (pause),
    .preset_sec (preset_sec),
    .sec_bcd    (sec_bcd),
    .cs_bcd     (cs_bcd),
    .running    (running),
    .expired    (expired),
    .time_up    (time_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_pulse();
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; tick_in = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    preset_sec = 8'h00;
    step(); step();
    rst = 1'b0;
    chk("rst_sec", 16'(sec_bcd), 16'h0060);
    chk("rst_cs", 16'(cs_bcd), 16'h0000);
    chk("rst_running", 16'(running), 16'h0);
    chk("rst_expired", 16'(expired), 16'h0);
    chk("rst_time_up", 16'(time_up), 16'h0);

    // Borrow chain: 10.00 -> 09.99 -> 09.98
    preset_sec = 8'h10; load = 1'b1; step(); load = 1'b0;
    chk("load10", {sec_bcd, cs_bcd}, 16'h1000);
    start = 1'b1; step(); start = 1'b0;
    chk("start_running", 16'(running), 16'h1);
    tick_in = 1'b1; step();
    chk("borrow_first", {sec_bcd, cs_bcd}, 16'h0999);
    repeat (4) step();
    chk("tick_held_high", {sec_bcd, cs_bcd}, 16'h0999);
    tick_in = 1'b0; step();
    tick_in = 1'b1; step();
    chk("second_edge", {sec_bcd, cs_bcd}, 16'h0998);
    tick_in = 1'b0; step();

    // Expiry: 01.00 minus 98 ticks = 00.02, two more reach 00.00
    preset_sec = 8'h01; load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 98; i++) tick_pulse();
    chk("exp_0002", {sec_bcd, cs_bcd}, 16'h0002);
    tick_in = 1'b1; step();
    chk("exp_0001", {sec_bcd, cs_bcd}, 16'h0001);
    chk("exp_no_pulse_yet", 16'(time_up), 16'h0);
    tick_in = 1'b0; step();
    tick_in = 1'b1; step();
    chk("exp_0000", {sec_bcd, cs_bcd}, 16'h0000);
    chk("exp_time_up", 16'(time_up), 16'h1);
    chk("exp_expired", 16'(expired), 16'h1);
    chk("exp_running", 16'(running), 16'h0);
    tick_in = 1'b0; step();
    chk("exp_pulse_one_cycle", 16'(time_up), 16'h0);
    repeat (3) tick_pulse();
    chk("exp_hold", {sec_bcd, cs_bcd}, 16'h0000);
    chk("exp_hold_time_up", 16'(time_up), 16'h0);
    chk("exp_hold_expired", 16'(expired), 16'h1);

    // Pause coinciding with a tick edge
    preset_sec = 8'h05; load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("pause_run", {15'h0, running}, 16'h1);
    tick_in = 1'b1; pause = 1'b1; step();
    pause = 1'b0; tick_in = 1'b0;
    chk("pause_tick_applied", {sec_bcd, cs_bcd}, 16'h0499);
    chk("pause_not_running", 16'(running), 16'h0);
    step();
    repeat (3) tick_pulse();
    chk("pause_frozen", {sec_bcd, cs_bcd}, 16'h0499);
    start = 1'b1; step(); start = 1'b0;
    chk("resume_running", 16'(running), 16'h1);
    tick_in = 1'b1; step();
    chk("resume_tick", {sec_bcd, cs_bcd}, 16'h0498);

    // Load priority over a coincident tick edge, with clamp
    tick_in = 1'b0; step();
    preset_sec = 8'hA7; load = 1'b1; tick_in = 1'b1; step(); load = 1'b0;
    chk("load_clamp", {sec_bcd, cs_bcd}, 16'h9700);
    chk("load_idle", 16'(running), 16'h0);
    step();
    tick_in = 1'b0; step();
    tick_pulse();
    chk("idle_ignores_tick", {sec_bcd, cs_bcd}, 16'h9700);

    // Zero start goes straight to DONE
    preset_sec = 8'h00; load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("zero_expired", 16'(expired), 16'h1);
    chk("zero_time_up", 16'(time_up), 16'h1);
    chk("zero_running", 16'(running), 16'h0);
    step();
    chk("zero_pulse_once", 16'(time_up), 16'h0);

    // Reset mid-RUN
    preset_sec = 8'h30; load = 1'b1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    tick_in = 1'b1; step();
    chk("mid_run_count", {sec_bcd, cs_bcd}, 16'h2999);
    chk("mid_run_running", 16'(running), 16'h1);
    tick_in = 1'b0; step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_count", {sec_bcd, cs_bcd}, 16'h6000);
    chk("mid_rst_running", 16'(running), 16'h0);
    chk("mid_rst_expired", 16'(expired), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
